// File: rtl/bridge_pkg.sv
// Shared types and constants for the bridge dataslot loader.
package bridge_pkg;

   // Bridge byte address as seen on the dataslot bus.
   typedef logic [31:0] bridge_addr_t;

   typedef enum logic [2:0] {
      LOADER_IDLE,
      LOADER_ARMED,
      LOADER_LOADING,
      LOADER_DONE,
      LOADER_ERROR
   } loader_state_t;

   typedef enum logic [1:0] {
      LOADER_ERR_NONE    = 2'd0,
      LOADER_ERR_ALIGN   = 2'd1,
      LOADER_ERR_SEQ     = 2'd2,
      LOADER_ERR_TIMEOUT = 2'd3
   } loader_err_t;

   // Every bridge write carries one 32-bit word.
   localparam logic [31:0] LOADER_WORD_BYTES = 32'd4;

   // Largest word-multiple byte count; the running count never exceeds it.
   localparam logic [31:0] LOADER_COUNT_MAX  = 32'hFFFF_FFFC;

   // A slot must start on an 8-byte boundary.
   function automatic logic base_aligned(input bridge_addr_t addr);
      return addr[2:0] == 3'b000;
   endfunction

endpackage

// File: rtl/bridge_loader_timeout.sv
// Idle-cycle watchdog for the dataslot loader: counts cycles without a bus
// write while a load is in progress and flags expiry on the last allowed one.
module bridge_loader_timeout #(
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
   input  logic clk,
   input  logic reset,
   input  logic run,      // loader is ARMED or LOADING
   input  logic clear,    // a bus write or an arming request this cycle
   output logic expired
);

   localparam logic [23:0] LAST_COUNT = TIMEOUT_CYCLES - 24'd1;

   logic [23:0] idle_cnt;

   // Expiry: count has reached its limit and nothing restarts it this cycle.
   assign expired = run && !clear && (idle_cnt == LAST_COUNT);

   // Idle counter: restarts on activity or outside a load, holds at the limit.
   always_ff @(posedge clk) begin
      if (reset || clear || !run) begin
         // NOTE: sequential state uses non-blocking assignments so every
         // register samples the pre-edge values of the others.
         idle_cnt <= '0;
      end else if (idle_cnt != LAST_COUNT) begin
         idle_cnt <= idle_cnt + 24'd1;
      end
   end

endmodule

// File: rtl/bridge_dataslot_loader.sv
// Passive sequencer for loading one data slot over the bridge dataslot bus.
// Arms on a matching host write request, checks that the following bus
// writes start aligned and run contiguously up to the announced size, and
// holds DONE/ERROR until the consumer acknowledges.
// Optional feature: define DATASLOT_LOADER_TIMEOUT_EN to abort a load after
// TIMEOUT_CYCLES idle cycles (error code 3).
module bridge_dataslot_loader
   import bridge_pkg::*;
#(
   parameter logic [15:0] SLOT_ID        = 16'h0000,
   parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_000_000
) (
   input  logic        clk,
   input  logic        reset,
   // bridge dataslot bus (observed only)
   input  logic        bridge_wr,
   input  logic [31:0] bridge_addr,
   input  logic [31:0] bridge_wr_data,
   // host dataslot write request (observed only)
   input  logic        req_valid,
   input  logic [15:0] req_slot_id,
   input  logic [31:0] req_expected_size,
   // consumer handshake and status
   input  logic        ack,
   output logic [31:0] slot_base_address,
   output logic [31:0] bytes_written,
   output logic [31:0] expected_size,
   output logic        loading,
   output logic        done,
   output logic        done_pulse,
   output logic        error,
   output logic [1:0]  error_code
);

   loader_state_t state_q, state_d;
   logic [31:0]   base_d, count_d, size_d;
   loader_err_t   err_d;
   logic          pulse_d;

   logic          req_hit;
   logic          timeout_hit;
   logic [32:0]   count_sum;
   logic [31:0]   count_inc;
   logic          count_reached;
   logic [31:0]   next_addr;

   assign req_hit = req_valid && (req_slot_id == SLOT_ID);

   // Next count after one more word; the 33-bit sum keeps the size compare
   // exact, and the stored value saturates at the largest word multiple.
   assign count_sum     = {1'b0, bytes_written} + {1'b0, LOADER_WORD_BYTES};
   assign count_reached = count_sum >= {1'b0, expected_size};
   assign count_inc     = (bytes_written == LOADER_COUNT_MAX) ? LOADER_COUNT_MAX
                                                              : count_sum[31:0];
   // Expected address of the next write, wrapping at 32 bits.
   assign next_addr     = slot_base_address + bytes_written;

`ifdef DATASLOT_LOADER_TIMEOUT_EN
   bridge_loader_timeout #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_timeout (
      .clk     (clk),
      .reset   (reset),
      .run     ((state_q == LOADER_ARMED) || (state_q == LOADER_LOADING)),
      .clear   (bridge_wr || req_hit),
      .expired (timeout_hit)
   );

   // Write data is never inspected; the loader only tracks addresses.
   logic unused_ok;
   assign unused_ok = &{1'b0, bridge_wr_data};
`else
   assign timeout_hit = 1'b0;

   // Write data and the timeout limit are not needed in this build.
   logic unused_ok;
   assign unused_ok = &{1'b0, bridge_wr_data, TIMEOUT_CYCLES};
`endif

   // Next-state and next-output logic; a matching request overrides
   // everything else, including a write or ack in the same cycle.
   always_comb begin
      // NOTE: every variable gets a default first so no path leaves one
      // unassigned, which would infer a latch.
      state_d = state_q;
      base_d  = slot_base_address;
      count_d = bytes_written;
      size_d  = expected_size;
      err_d   = loader_err_t'(error_code);
      pulse_d = 1'b0;

      if (req_hit) begin
         size_d  = req_expected_size;
         count_d = '0;
         err_d   = LOADER_ERR_NONE;
         if (req_expected_size == 32'd0) begin
            state_d = LOADER_DONE;
            pulse_d = 1'b1;
         end else begin
            state_d = LOADER_ARMED;
         end
      end else begin
         unique case (state_q)
            LOADER_ARMED: begin
               if (bridge_wr) begin
                  base_d = bridge_addr;
                  if (!base_aligned(bridge_addr)) begin
                     state_d = LOADER_ERROR;
                     err_d   = LOADER_ERR_ALIGN;
                  end else begin
                     count_d = LOADER_WORD_BYTES;
                     if (LOADER_WORD_BYTES >= expected_size) begin
                        state_d = LOADER_DONE;
                        pulse_d = 1'b1;
                     end else begin
                        state_d = LOADER_LOADING;
                     end
                  end
               end else if (timeout_hit) begin
                  state_d = LOADER_ERROR;
                  err_d   = LOADER_ERR_TIMEOUT;
               end
            end

            LOADER_LOADING: begin
               if (bridge_wr) begin
                  if (bridge_addr == next_addr) begin
                     count_d = count_inc;
                     if (count_reached) begin
                        state_d = LOADER_DONE;
                        pulse_d = 1'b1;
                     end
                  end else begin
                     state_d = LOADER_ERROR;
                     err_d   = LOADER_ERR_SEQ;
                  end
               end else if (timeout_hit) begin
                  state_d = LOADER_ERROR;
                  err_d   = LOADER_ERR_TIMEOUT;
               end
            end

            LOADER_DONE, LOADER_ERROR: begin
               if (ack) begin
                  state_d = LOADER_IDLE;
                  err_d   = LOADER_ERR_NONE;
               end
            end

            default: begin
               // IDLE waits for a request; writes and acks are ignored.
            end
         endcase
      end
   end

   // State and registered outputs, all decoded from the next state.
   always_ff @(posedge clk) begin
      if (reset) begin
         // NOTE: only control and status registers exist here, so every one
         // is reset; there is no storage array to leave uninitialised.
         state_q           <= LOADER_IDLE;
         slot_base_address <= '0;
         bytes_written     <= '0;
         expected_size     <= '0;
         loading           <= 1'b0;
         done              <= 1'b0;
         done_pulse        <= 1'b0;
         error             <= 1'b0;
         error_code        <= LOADER_ERR_NONE;
      end else begin
         state_q           <= state_d;
         slot_base_address <= base_d;
         bytes_written     <= count_d;
         expected_size     <= size_d;
         loading           <= (state_d == LOADER_ARMED) || (state_d == LOADER_LOADING);
         done              <= (state_d == LOADER_DONE);
         done_pulse        <= pulse_d;
         error             <= (state_d == LOADER_ERROR);
         error_code        <= err_d;
      end
   end

endmodule

// File: tb/tb_bridge_dataslot_loader.sv
// Self-checking bench for bridge_dataslot_loader: directed scenarios followed
// by randomized traffic, all compared against a transaction-level model.
module tb_bridge_dataslot_loader;

   localparam logic [15:0] SLOT   = 16'h0005;
   localparam int          TO_CYC = 8;

   // model phases
   localparam int P_IDLE = 0, P_ARMED = 1, P_LOADING = 2, P_DONE = 3, P_ERROR = 4;

   logic        clk = 1'b0;
   logic        reset;
   logic        bridge_wr;
   logic [31:0] bridge_addr;
   logic [31:0] bridge_wr_data;
   logic        req_valid;
   logic [15:0] req_slot_id;
   logic [31:0] req_expected_size;
   logic        ack;
   logic [31:0] slot_base_address;
   logic [31:0] bytes_written;
   logic [31:0] expected_size;
   logic        loading;
   logic        done;
   logic        done_pulse;
   logic        error;
   logic [1:0]  error_code;

   always #5 clk = ~clk;

   bridge_dataslot_loader #(
      .SLOT_ID        (SLOT),
      .TIMEOUT_CYCLES (24'(TO_CYC))
   ) dut (
      .clk               (clk),
      .reset             (reset),
      .bridge_wr         (bridge_wr),
      .bridge_addr       (bridge_addr),
      .bridge_wr_data    (bridge_wr_data),
      .req_valid         (req_valid),
      .req_slot_id       (req_slot_id),
      .req_expected_size (req_expected_size),
      .ack               (ack),
      .slot_base_address (slot_base_address),
      .bytes_written     (bytes_written),
      .expected_size     (expected_size),
      .loading           (loading),
      .done              (done),
      .done_pulse        (done_pulse),
      .error             (error),
      .error_code        (error_code)
   );

   int n_cmp = 0;
   int n_bad = 0;

   // reference model of the loader's observable status
   int          m_phase = P_IDLE;
   logic [31:0] m_base  = '0;
   logic [31:0] m_count = '0;
   logic [31:0] m_size  = '0;
   int          m_err   = 0;
   bit          m_pulse = 1'b0;
   int          m_idle  = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s @%0t: got %h expected %h", tag, $time, got, exp);
      end
   endtask

   // Advance the model by one clock using the inputs sampled at that edge.
   task automatic model_step(input bit rst, input bit valid, input logic [15:0] slot,
                             input logic [31:0] size, input bit wr,
                             input logic [31:0] addr, input bit ak);
      logic [63:0] grown;
      logic [31:0] want;
      m_pulse = 1'b0;
      if (rst) begin
         m_phase = P_IDLE; m_base = '0; m_count = '0; m_size = '0; m_err = 0; m_idle = 0;
         return;
      end
      if (valid && slot == SLOT) begin
         m_size  = size;
         m_count = '0;
         m_err   = 0;
         m_idle  = 0;
         if (size == 0) begin m_phase = P_DONE; m_pulse = 1'b1; end
         else m_phase = P_ARMED;
         return;
      end
      if (wr) m_idle = 0;
      if (m_phase == P_ARMED && wr) begin
         m_base = addr;
         if (addr % 8 != 0) begin
            m_phase = P_ERROR; m_err = 1;
         end else begin
            m_count = 4;
            if (m_size <= 4) begin m_phase = P_DONE; m_pulse = 1'b1; end
            else m_phase = P_LOADING;
         end
      end else if (m_phase == P_LOADING && wr) begin
         want = m_base + m_count;
         if (addr == want) begin
            grown = {32'd0, m_count} + 64'd4;
            if (grown >= {32'd0, m_size}) begin m_phase = P_DONE; m_pulse = 1'b1; end
            m_count = (grown > 64'hFFFF_FFFC) ? 32'hFFFF_FFFC : grown[31:0];
         end else begin
            m_phase = P_ERROR; m_err = 2;
         end
      end else if ((m_phase == P_DONE || m_phase == P_ERROR) && ak) begin
         m_phase = P_IDLE; m_err = 0;
      end
`ifdef DATASLOT_LOADER_TIMEOUT_EN
      else if ((m_phase == P_ARMED || m_phase == P_LOADING) && !wr) begin
         m_idle++;
         if (m_idle >= TO_CYC) begin m_phase = P_ERROR; m_err = 3; end
      end
`endif
   endtask

   task automatic compare_all();
      check("loading",    32'(loading),    32'(m_phase == P_ARMED || m_phase == P_LOADING));
      check("done",       32'(done),       32'(m_phase == P_DONE));
      check("done_pulse", 32'(done_pulse), 32'(m_pulse));
      check("error",      32'(error),      32'(m_phase == P_ERROR));
      check("error_code", 32'(error_code), 32'(m_err));
      check("base",       slot_base_address, m_base);
      check("count",      bytes_written,     m_count);
      check("size",       expected_size,     m_size);
   endtask

   // One clock: drive inputs, clock them in, update the model, compare.
   task automatic cyc(input bit rst, input bit valid, input logic [15:0] slot,
                      input logic [31:0] size, input bit wr,
                      input logic [31:0] addr, input bit ak);
      reset             = rst;
      req_valid         = valid;
      req_slot_id       = slot;
      req_expected_size = size;
      bridge_wr         = wr;
      bridge_addr       = addr;
      bridge_wr_data    = $urandom;
      ack               = ak;
      @(posedge clk);
      model_step(rst, valid, slot, size, wr, addr, ak);
      #1;
      compare_all();
      reset = 1'b0; req_valid = 1'b0; bridge_wr = 1'b0; ack = 1'b0;
   endtask

   task automatic idle();                      cyc(0, 0, 16'h0, 32'h0, 0, 32'h0, 0); endtask
   task automatic req(input logic [31:0] sz);   cyc(0, 1, SLOT,  sz,    0, 32'h0, 0); endtask
   task automatic wr(input logic [31:0] a);     cyc(0, 0, 16'h0, 32'h0, 1, a,     0); endtask
   task automatic do_ack();                     cyc(0, 0, 16'h0, 32'h0, 0, 32'h0, 1); endtask

   initial begin
      reset = 1'b1; req_valid = 1'b0; req_slot_id = '0; req_expected_size = '0;
      bridge_wr = 1'b0; bridge_addr = '0; bridge_wr_data = '0; ack = 1'b0;

      // reset state
      cyc(1, 0, 16'h0, 32'h0, 0, 32'h0, 0);
      cyc(1, 0, 16'h0, 32'h0, 0, 32'h0, 0);
      check("rst_loading", 32'(loading), 32'd0);
      check("rst_code",    32'(error_code), 32'd0);
      check("rst_size",    expected_size, 32'd0);

      // clean load of 16 bytes
      req(32'd16);
      check("clean_armed", 32'(loading), 32'd1);
      wr(32'h1000); wr(32'h1004); wr(32'h1008);
      check("clean_nodone", 32'(done), 32'd0);
      wr(32'h100C);
      check("clean_pulse", 32'(done_pulse), 32'd1);
      check("clean_base",  slot_base_address, 32'h1000);
      check("clean_count", bytes_written, 32'd16);
      idle();
      check("clean_pulse_drop", 32'(done_pulse), 32'd0);
      check("clean_hold",       32'(done), 32'd1);
      do_ack();
      check("clean_ack", 32'(done), 32'd0);

      // size zero and partial final word
      req(32'd0);
      check("zero_done",  32'(done), 32'd1);
      check("zero_pulse", 32'(done_pulse), 32'd1);
      do_ack();
      req(32'd5);
      wr(32'h2000); wr(32'h2004);
      check("partial_done",  32'(done), 32'd1);
      check("partial_count", bytes_written, 32'd8);
      do_ack();

      // misaligned base
      req(32'd16);
      wr(32'h1002);
      check("align_err",  32'(error), 32'd1);
      check("align_code", 32'(error_code), 32'd1);
      do_ack();
      check("align_ack_code", 32'(error_code), 32'd0);

      // non-sequential write
      req(32'd16);
      wr(32'h1000); wr(32'h1008);
      check("seq_code",  32'(error_code), 32'd2);
      check("seq_count", bytes_written, 32'd4);
      do_ack();

      // foreign slot ignored, abort restarts, reset clears
      req(32'd16);
      wr(32'h1000);
      cyc(0, 1, 16'h0009, 32'd99, 0, 32'h0, 0);
      check("foreign_size", expected_size, 32'd16);
      cyc(0, 1, SLOT, 32'd32, 1, 32'h1004, 0);
      check("abort_count",   bytes_written, 32'd0);
      check("abort_size",    expected_size, 32'd32);
      check("abort_loading", 32'(loading), 32'd1);
      wr(32'h3000); wr(32'h3004);
      cyc(1, 0, 16'h0, 32'h0, 0, 32'h0, 0);
      check("midrst_count", bytes_written, 32'd0);
      check("midrst_base",  slot_base_address, 32'd0);

      // idle watchdog
      req(32'd16);
`ifdef DATASLOT_LOADER_TIMEOUT_EN
      for (int i = 0; i < TO_CYC - 1; i++) idle();
      check("to_not_yet", 32'(error), 32'd0);
      idle();
      check("to_err",  32'(error), 32'd1);
      check("to_code", 32'(error_code), 32'd3);
      do_ack();
`else
      for (int i = 0; i < 100; i++) idle();
      check("no_to_loading", 32'(loading), 32'd1);
      cyc(1, 0, 16'h0, 32'h0, 0, 32'h0, 0);
`endif

      // randomized traffic
      for (int i = 0; i < 4000; i++) begin
         bit          r_rst, r_valid, r_wr, r_ack;
         logic [15:0] r_slot;
         logic [31:0] r_size, r_addr;
         r_rst   = ($urandom_range(0, 199) == 0);
         r_valid = ($urandom_range(0, 99) < 5);
         r_slot  = ($urandom_range(0, 4) == 0) ? 16'($urandom) : SLOT;
         r_size  = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 8))
                                               : 32'($urandom_range(1, 64));
         r_wr    = ($urandom_range(0, 99) < 60);
         r_ack   = ($urandom_range(0, 99) < 15);
         r_addr  = $urandom;
         if (m_phase == P_LOADING && $urandom_range(0, 99) < 90)
            r_addr = m_base + m_count;
         else if (m_phase == P_ARMED && $urandom_range(0, 99) < 85)
            r_addr = r_addr & 32'hFFFF_FFF8;
         cyc(r_rst, r_valid, r_slot, r_size, r_wr, r_addr, r_ack);
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule

// File: doc/bridge_dataslot_loader.md
# bridge_dataslot_loader

Sequences the load of one data slot over the bridge dataslot bus. Arms on a matching `host_dataslot_request_write`, then tracks the bridge writes that follow, checking alignment, contiguity and length against the announced size. It reports loading/done/error status to the core logic consuming the slot and holds the result until that logic acknowledges. Sits beside the bridge dataslot bus as a passive observer: it never drives bus signals.

## Interface
Parameters:
- `SLOT_ID`, 16'h0000: slot id to load; requests for other ids are ignored.
- `TIMEOUT_CYCLES`, 24'd1_000_000: idle-cycle limit between bus writes. Only used with the timeout macro.

Ports:
- `bridge_dataslot.clk`: in, 1. Sole clock; all logic on its rising edge.
- `reset`: in, 1. Synchronous, active-high.
- `bridge_dataslot`: bus_if, observed only. Uses `wr`, `addr` (32), `wr_data` (32).
- `host_dataslot_request_write`: host_dataslot_request_write_if, observed only. Uses `valid`, `param.slot_id` (16), `param.expected_size` (32, bytes).
- `ack`: in, 1. Consumer releases DONE/ERROR.
- `slot_base_address`: out, `pocket::bridge_addr_t`. Address of the first write.
- `bytes_written`: out, 32. Running byte count.
- `expected_size`: out, 32. Latched size.
- `loading`: out, 1. High in ARMED or LOADING.
- `done`: out, 1. High in DONE.
- `done_pulse`: out, 1. One cycle on entry to DONE.
- `error`: out, 1. High in ERROR.
- `error_code`: out, `bridge_pkg::loader_err_t` (2). Values: 0 none, 1 misaligned base, 2 non-sequential, 3 timeout.

## Operation
States: IDLE, ARMED, LOADING, DONE, ERROR.

- **Reset** (any state): go to IDLE. All outputs 0, including `slot_base_address`, `bytes_written`, `expected_size` and `error_code`.
- **Arming request**: `valid` with `slot_id == SLOT_ID`, accepted in any state.
  - Latches `expected_size`, clears `bytes_written` and `error_code`.
  - Goes to ARMED, or straight to DONE if size is 0 (`done_pulse` fires).
  - A request during LOADING, DONE or ERROR aborts the current load and restarts it.
- **ARMED**: the first bus write (`wr`=1) sets `slot_base_address` = `addr`.
  - If `addr[2:0] != 0`: go to ERROR, code 1.
  - Otherwise: `bytes_written` = 4, then go to LOADING, or to DONE if 4 >= size.
- **LOADING**: each write must have `addr == slot_base_address + bytes_written` (32-bit wrap arithmetic).
  - Match: `bytes_written` += 4. When the new count >= `expected_size`, go to DONE. A final partial word counts as a full word.
  - Mismatch: go to ERROR, code 2; the count is not updated.
- **DONE / ERROR**: outputs hold; bus writes are ignored. `ack` returns to IDLE and clears `error_code`; `bytes_written` and `slot_base_address` keep their values.
- **Simultaneous events**:
  - Request and write in the same cycle: the request wins and the write is ignored.
  - Request and `ack` in the same cycle: the request wins.
  - `ack` outside DONE/ERROR: no effect.
- `bytes_written` saturates at 32'hFFFF_FFFC; the size comparison happens before it can overflow.

## Timing
- All outputs are registered.
- Status changes appear the cycle after the triggering edge. Example: a request in cycle N gives `loading`=1 in N+1.
- Last qualifying write in cycle N: `done`=1 and `done_pulse`=1 in N+1; `done_pulse` drops in N+2.
- `ack` in cycle N gives IDLE in N+1.
- No back-pressure: every write cycle must be processed at one write per clock.

## Configuration
- `DATASLOT_LOADER_TIMEOUT_EN` defined: a 24-bit idle counter runs in ARMED and LOADING.
  - It clears on every write and on every arming request.
  - When it reaches `TIMEOUT_CYCLES - 1` with no write that cycle, go to ERROR, code 3.
- Not defined: no counter, code 3 is never produced, and ARMED/LOADING wait indefinitely.

## Structure
- `bridge_pkg` gains:
  - `loader_state_t`, an enum of the 5 states.
  - `loader_err_t`, a 2-bit enum with `LOADER_ERR_NONE`, `LOADER_ERR_ALIGN`, `LOADER_ERR_SEQ`, `LOADER_ERR_TIMEOUT`.
  - The constant `LOADER_WORD_BYTES = 4`.
- One natural sub-module: `bridge_loader_timeout` holds the idle counter. It is instantiated only under the macro.
- The FSM and address checks stay in the top module.

## Test plan
- **Clean load**: request size 16, slot matches; writes at 0x1000, 0x1004, 0x1008, 0x100C → `slot_base_address`=0x1000, `bytes_written`=16, `done_pulse` one cycle after the 4th write; `ack` → IDLE.
- **Size zero and partial word**: request size 0 → DONE the next cycle with no writes. Request size 5, writes at 0x2000 and 0x2004 → DONE with `bytes_written`=8.
- **Errors**:
  - First write at 0x1002 → ERROR, code 1.
  - Writes at 0x1000 then 0x1008 → ERROR, code 2, `bytes_written`=4.
- **Non-matching slot and abort**:
  - A request with a different `slot_id` causes no state change.
  - A matching request mid-LOAD with the same-cycle write ignored → ARMED, count 0.
  - Reset mid-LOAD → all outputs 0 the next cycle.
- **Timeout (macro on)**: `TIMEOUT_CYCLES`=8; arm, then no writes → ERROR, code 3 exactly 8 cycles after arming. With the macro off, the block is still ARMED after 100 cycles.
